// File: rtl/serial_operand_shift_reg.sv
// Parallel-load, serial-out operand register for the bit-serial adder/subtractor.
// Configurable width, bit order, output inversion and rotate/zero-fill shifting.
module serial_operand_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter bit          INVERT    = 1'b0,
    parameter bit          RECIRC    = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             L,
    input  logic [WIDTH-1:0] Load,
    input  logic             EN,
    output logic             Sout,
    output logic             First,
    output logic             Last,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Q
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    r_count;
    logic             r_done;

    logic             w_sel_bit;
    logic             w_fill;
    logic [WIDTH-1:0] w_shifted;
    logic             w_busy;

    always_comb begin
        w_sel_bit = LSB_FIRST ? r_reg[0] : r_reg[WIDTH-1];
        // Recirculated bit is the stored value, never the inverted output.
        w_fill    = RECIRC ? w_sel_bit : 1'b0;
        w_shifted = LSB_FIRST ? {w_fill, r_reg[WIDTH-1:1]} : {r_reg[WIDTH-2:0], w_fill};
        w_busy    = (r_state == StShift);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_reg   <= '0;
            r_count <= '0;
            r_state <= StIdle;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (L) begin
                r_reg   <= Load;
                r_count <= '0;
                r_state <= StShift;
            end else if (r_state == StShift && EN) begin
                r_reg <= w_shifted;
                if (r_count == LastCount) begin
                    r_count <= '0;
                    r_state <= StIdle;
                    r_done  <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        Sout  = w_busy & (w_sel_bit ^ INVERT);
        First = w_busy && (r_count == '0);
        Last  = w_busy && (r_count == LastCount);
        Busy  = w_busy;
        Done  = r_done;
        Q     = r_reg;
    end

endmodule

// File: tb/tb_serial_operand_shift_reg.sv
// Directed bench: four configurations share one stimulus stream and are
// checked against hand-derived bit sequences.
module tb_serial_operand_shift_reg;

    logic       clk = 1'b0;
    logic       rst, l, en;
    logic [7:0] load;

    logic       s_lsb, f_lsb, la_lsb, b_lsb, d_lsb;
    logic       s_inv, f_inv, la_inv, b_inv, d_inv;
    logic       s_msb, f_msb, la_msb, b_msb, d_msb;
    logic       s_rot, f_rot, la_rot, b_rot, d_rot;
    logic [7:0] q_lsb, q_inv, q_msb, q_rot;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_operand_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b1), .INVERT(1'b0), .RECIRC(1'b0)) u_lsb (
        .CLK(clk), .RST(rst), .L(l), .Load(load), .EN(en), .Sout(s_lsb), .First(f_lsb),
        .Last(la_lsb), .Busy(b_lsb), .Done(d_lsb), .Q(q_lsb));
    serial_operand_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b1), .INVERT(1'b1), .RECIRC(1'b0)) u_inv (
        .CLK(clk), .RST(rst), .L(l), .Load(load), .EN(en), .Sout(s_inv), .First(f_inv),
        .Last(la_inv), .Busy(b_inv), .Done(d_inv), .Q(q_inv));
    serial_operand_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b0), .INVERT(1'b0), .RECIRC(1'b0)) u_msb (
        .CLK(clk), .RST(rst), .L(l), .Load(load), .EN(en), .Sout(s_msb), .First(f_msb),
        .Last(la_msb), .Busy(b_msb), .Done(d_msb), .Q(q_msb));
    serial_operand_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b1), .INVERT(1'b0), .RECIRC(1'b1)) u_rot (
        .CLK(clk), .RST(rst), .L(l), .Load(load), .EN(en), .Sout(s_rot), .First(f_rot),
        .Last(la_rot), .Busy(b_rot), .Done(d_rot), .Q(q_rot));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] op;

    initial begin
        rst = 1'b1; l = 1'b0; en = 1'b0; load = 8'h00;
        tick();
        rst = 1'b0;
        check("rst_sout", {28'b0, s_lsb, s_inv, s_msb, s_rot}, 32'h0);
        check("rst_busy", {28'b0, b_lsb, b_inv, b_msb, b_rot}, 32'h0);
        check("rst_first_last", {30'b0, f_lsb, la_lsb}, 32'h0);
        check("rst_done", {28'b0, d_lsb, d_inv, d_msb, d_rot}, 32'h0);
        check("rst_q", {q_lsb, q_inv, q_msb, q_rot}, 32'h0);

        // Full pass of 10100100 with continuous EN.
        op = 8'b1010_0100;
        l = 1'b1; load = op; en = 1'b1;
        tick();
        l = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("p1_lsb_b%0d", k), {31'b0, s_lsb}, {31'b0, op[k]});
            check($sformatf("p1_inv_b%0d", k), {31'b0, s_inv}, {31'b0, ~op[k]});
            check($sformatf("p1_msb_b%0d", k), {31'b0, s_msb}, {31'b0, op[7-k]});
            check($sformatf("p1_rot_b%0d", k), {31'b0, s_rot}, {31'b0, op[k]});
            check($sformatf("p1_first_b%0d", k), {31'b0, f_lsb}, {31'b0, k == 0});
            check($sformatf("p1_last_b%0d", k), {31'b0, la_msb}, {31'b0, k == 7});
            check($sformatf("p1_busy_b%0d", k), {31'b0, b_lsb}, 32'h1);
            check($sformatf("p1_done_b%0d", k), {31'b0, d_lsb}, 32'h0);
            tick();
        end
        check("p1_done", {28'b0, d_lsb, d_inv, d_msb, d_rot}, 32'hF);
        check("p1_busy_end", {28'b0, b_lsb, b_inv, b_msb, b_rot}, 32'h0);
        check("p1_sout_end", {28'b0, s_lsb, s_inv, s_msb, s_rot}, 32'h0);
        check("p1_q_zero_fill", {16'b0, q_lsb, q_msb}, 32'h0);
        check("p1_q_rotate", {24'b0, q_rot}, 32'hA4);
        // EN stays high in IDLE: must be ignored.
        tick();
        check("idle_done_drop", {28'b0, d_lsb, d_inv, d_msb, d_rot}, 32'h0);
        check("idle_q_hold", {24'b0, q_rot}, 32'hA4);
        check("idle_busy", {31'b0, b_rot}, 32'h0);

        // Abort after three bits with a new operand, then gapped EN.
        l = 1'b1; load = 8'b1010_0100;
        tick();
        l = 1'b0;
        tick(); tick(); tick();
        check("ab_pre_bit3", {31'b0, s_lsb}, 32'h0);
        op = 8'b0110_1101;
        l = 1'b1; load = op;
        tick();
        l = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ab_bit%0d", k), {31'b0, s_lsb}, {31'b0, op[k]});
            check($sformatf("ab_done%0d", k), {31'b0, d_lsb}, 32'h0);
            en = 1'b0;
            tick();
            check($sformatf("ab_hold%0d", k), {31'b0, s_lsb}, {31'b0, op[k]});
            check($sformatf("ab_hold_inv%0d", k), {31'b0, s_inv}, {31'b0, ~op[k]});
            check($sformatf("ab_hold_first%0d", k), {31'b0, f_lsb}, {31'b0, k == 0});
            check($sformatf("ab_hold_last%0d", k), {31'b0, la_lsb}, {31'b0, k == 7});
            en = 1'b1;
            tick();
        end
        check("ab_done", {31'b0, d_lsb}, 32'h1);
        check("ab_q_rotate", {24'b0, q_rot}, 32'h6D);
        en = 1'b0;
        tick();

        // Reset mid-shift at count 4.
        l = 1'b1; load = 8'b1010_0100; en = 1'b1;
        tick();
        l = 1'b0;
        tick(); tick(); tick(); tick();
        check("mid_busy", {31'b0, b_rot}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", {28'b0, b_lsb, b_inv, b_msb, b_rot}, 32'h0);
        check("mrst_sout", {28'b0, s_lsb, s_inv, s_msb, s_rot}, 32'h0);
        check("mrst_q", {q_lsb, q_inv, q_msb, q_rot}, 32'h0);
        check("mrst_done", {28'b0, d_lsb, d_inv, d_msb, d_rot}, 32'h0);

        // Reset and load at the same edge: reset wins.
        rst = 1'b1; l = 1'b1; load = 8'hFF;
        tick();
        rst = 1'b0; l = 1'b0; en = 1'b0;
        check("rl_busy", {28'b0, b_lsb, b_inv, b_msb, b_rot}, 32'h0);
        check("rl_q", {q_lsb, q_inv, q_msb, q_rot}, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
